// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// PC source selector codes and the hard-wired zero register index.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones,
// cleared asynchronously by clr.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count one event per cycle, holding once the counter is full
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// MEM-stage redirects, a freeze while slow data memory is busy (with a
// timeout), and saturating stall/flush debug counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_writeReg,
  input  logic             ex_MemToReg,
  input  logic             mem_BranchEq,
  input  logic             mem_zero,
  input  logic             mem_Jump,
  input  logic             mem_MemToReg,
  input  logic             mem_MemWrite,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       pc_src,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic           errTimeout_q, errTimeout_d;

  logic taken, redirect, memReq, loadUse;
  logic freeze, redirectFlush, bubble;
  logic [1:0] pcSrc;

  assign taken    = mem_BranchEq & mem_zero;
  assign redirect = taken | mem_Jump;
  assign memReq   = mem_MemToReg | mem_MemWrite;
  assign loadUse  = ex_MemToReg && (ex_writeReg != REG_ZERO) &&
                    ((ex_writeReg == id_rs) || (id_uses_rt && (ex_writeReg == id_rt)));

  // State, memory-wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= RUN;
      waitCnt_q    <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  // Pick this cycle's action by priority: memory wait, redirect, load-use bubble
  always_comb begin
    state_d       = state_q;
    waitCnt_d     = waitCnt_q;
    errTimeout_d  = errTimeout_q;
    freeze        = 1'b0;
    redirectFlush = 1'b0;
    bubble        = 1'b0;
    pcSrc         = PCSRC_SEQ;
    case (state_q)
      RUN: begin
        if (memReq && !mem_ready) begin
          freeze    = 1'b1;
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end else if (redirect) begin
          redirectFlush = 1'b1;
          pcSrc         = mem_Jump ? PCSRC_J : PCSRC_BR;
        end else if (loadUse) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == WCW'(MEM_TIMEOUT)) begin
          state_d      = RUN;
          waitCnt_d    = '0;
          errTimeout_d = 1'b1;
        end else begin
          freeze    = 1'b1;
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
    if (clr) begin
      freeze        = 1'b0;
      redirectFlush = 1'b0;
      bubble        = 1'b0;
      pcSrc         = PCSRC_SEQ;
    end
  end

  assign pc_hold     = freeze | bubble;
  assign ifid_hold   = freeze | bubble;
  assign ifid_flush  = redirectFlush;
  assign idex_hold   = freeze;
  assign idex_flush  = redirectFlush | bubble;
  assign exmem_hold  = freeze;
  assign exmem_flush = redirectFlush;
  assign memwb_flush = freeze;
  assign pc_src      = pcSrc;
  assign err_timeout = errTimeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (pc_hold),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (redirectFlush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = 7;

  localparam int ACT_NONE     = 0;
  localparam int ACT_FREEZE   = 1;
  localparam int ACT_REDIRECT = 2;
  localparam int ACT_BUBBLE   = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_writeReg = '0;
  logic id_uses_rt = 0, ex_MemToReg = 0, mem_BranchEq = 0, mem_zero = 0;
  logic mem_Jump = 0, mem_MemToReg = 0, mem_MemWrite = 0, mem_ready = 0;

  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
  logic exmem_hold, exmem_flush, memwb_flush, err_timeout;
  logic [1:0] pc_src;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_writeReg  (ex_writeReg),
    .ex_MemToReg  (ex_MemToReg),
    .mem_BranchEq (mem_BranchEq),
    .mem_zero     (mem_zero),
    .mem_Jump     (mem_Jump),
    .mem_MemToReg (mem_MemToReg),
    .mem_MemWrite (mem_MemWrite),
    .mem_ready    (mem_ready),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_hold    (idex_hold),
    .idex_flush   (idex_flush),
    .exmem_hold   (exmem_hold),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .pc_src       (pc_src),
    .err_timeout  (err_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Control vector a given pipeline action must produce, ordered
  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_flush, memwb_flush}
  function automatic logic [7:0] ctrlFor(input int act);
    case (act)
      ACT_FREEZE:   return 8'b1101_0101;
      ACT_REDIRECT: return 8'b0010_1010;
      ACT_BUBBLE:   return 8'b1100_1000;
      default:      return 8'b0000_0000;
    endcase
  endfunction

  // Model state: waiting on memory, frozen cycles spent waiting, error, counters
  bit mWait = 0;
  int mWaitCycles = 0;
  bit mErr = 0;
  int mStalls = 0, mFlushes = 0;
  bit nWait, nErr;
  int nWaitCycles, nStalls, nFlushes;
  int action, expSrc;
  bit isLoadUse, isRedirect, isMemBusy;
  logic [7:0] expCtrl;

  // Decide the expected action from the rules and compare every output
  always @(negedge clk) begin
    if (checkEn) begin
      nWait = mWait; nWaitCycles = mWaitCycles; nErr = mErr;
      action = ACT_NONE; expSrc = 0;
      isRedirect = (mem_BranchEq && mem_zero) || mem_Jump;
      isMemBusy  = (mem_MemToReg || mem_MemWrite) && !mem_ready;
      isLoadUse  = ex_MemToReg && ex_writeReg != 0 &&
                   (ex_writeReg == id_rs || (id_uses_rt && ex_writeReg == id_rt));
      if (!clr) begin
        if (!mWait) begin
          if (isMemBusy) begin
            action = ACT_FREEZE; nWait = 1; nWaitCycles = 0;
          end else if (isRedirect) begin
            action = ACT_REDIRECT; expSrc = mem_Jump ? 2 : 1;
          end else if (isLoadUse) begin
            action = ACT_BUBBLE;
          end
        end else if (mem_ready) begin
          nWait = 0; nWaitCycles = 0;
        end else if (mWaitCycles >= MEM_TIMEOUT) begin
          nWait = 0; nWaitCycles = 0; nErr = 1;
        end else begin
          action = ACT_FREEZE; nWaitCycles = mWaitCycles + 1;
        end
      end
      expCtrl = ctrlFor(action);
      checkOutput("ctrl", int'({pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                                exmem_hold, exmem_flush, memwb_flush}), int'(expCtrl));
      checkOutput("pcSrc", int'(pc_src), expSrc);
      checkOutput("errTimeout", int'(err_timeout), int'(mErr));
      checkOutput("stallCnt", int'(stall_cnt), mStalls);
      checkOutput("flushCnt", int'(flush_cnt), mFlushes);
      checkOutput("holdFlushExclusive", int'((ifid_hold & ifid_flush) | (idex_hold & idex_flush) |
                                             (exmem_hold & exmem_flush)), 0);
      nStalls  = (expCtrl[7] && mStalls < CNT_MAX) ? mStalls + 1 : mStalls;
      nFlushes = (action == ACT_REDIRECT && mFlushes < CNT_MAX) ? mFlushes + 1 : mFlushes;
    end
  end

  // Advance the model on the clock edge; reset it with the DUT
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mWait <= 0; mWaitCycles <= 0; mErr <= 0; mStalls <= 0; mFlushes <= 0;
    end else if (checkEn) begin
      mWait <= nWait; mWaitCycles <= nWaitCycles; mErr <= nErr;
      mStalls <= nStalls; mFlushes <= nFlushes;
    end
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic [4:0] exWr, input logic exLoad,
                               input logic brEq, input logic zero, input logic jump,
                               input logic mLoad, input logic mStore, input logic ready);
    id_rs = rs; id_rt = rt; id_uses_rt = usesRt;
    ex_writeReg = exWr; ex_MemToReg = exLoad;
    mem_BranchEq = brEq; mem_zero = zero; mem_Jump = jump;
    mem_MemToReg = mLoad; mem_MemWrite = mStore; mem_ready = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    nextCycle();
    clr = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    clr = 1'b0;
  endtask

  // Directed scenarios with hand-computed expectations
  initial begin
    #2 clr = 1'b1;
    checkEn = 1;

    // Reset with load-use inputs active: everything quiet
    applyStimulus(8, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rstPcHold", pc_hold, 0);
    checkOutput("rstIdexFlush", idex_flush, 0);
    checkOutput("rstStallCnt", stall_cnt, 0);
    checkOutput("rstFlushCnt", flush_cnt, 0);

    // lw $8 in EX, add $9,$8,$1 in ID: one bubble
    nextCycle();
    clr = 1'b0;
    @(negedge clk);
    checkOutput("luPcHold", pc_hold, 1);
    checkOutput("luIfidHold", ifid_hold, 1);
    checkOutput("luIdexFlush", idex_flush, 1);
    nextCycle();
    applyStimulus(9, 8, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luAfterPcHold", pc_hold, 0);
    checkOutput("luAfterStallCnt", stall_cnt, 1);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luZeroRegNoStall", pc_hold, 0);
    nextCycle();
    applyStimulus(2, 8, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luRtMatch", pc_hold, 1);
    nextCycle();
    applyStimulus(2, 8, 0, 8, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luRtUnused", pc_hold, 0);

    // Taken branch, then untaken
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("brIfidFlush", ifid_flush, 1);
    checkOutput("brExmemFlush", exmem_flush, 1);
    checkOutput("brPcSrc", pc_src, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("brNtFlush", ifid_flush, 0);
    checkOutput("brNtPcSrc", pc_src, 0);
    checkOutput("brFlushCnt", flush_cnt, 1);

    // Jump wins over a simultaneous load-use
    resetDut();
    applyStimulus(8, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("jPcSrc", pc_src, 2);
    checkOutput("jPcHold", pc_hold, 0);
    checkOutput("jIdexFlush", idex_flush, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("jStallCnt", stall_cnt, 0);
    checkOutput("jFlushCnt", flush_cnt, 1);

    // Load waits 3 cycles; a jump in the first cycle loses to the wait
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mwFreeze%0d", i), pc_hold, 1);
      checkOutput($sformatf("mwBubble%0d", i), memwb_flush, 1);
      checkOutput($sformatf("mwNoFlush%0d", i), ifid_flush, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    checkOutput("mwReleasePc", pc_hold, 0);
    checkOutput("mwReleaseExmem", exmem_hold, 0);
    checkOutput("mwReleaseWb", memwb_flush, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mwStallCnt", stall_cnt, 3);
    checkOutput("mwFlushCnt", flush_cnt, 0);
    checkOutput("mwBackToRun", pc_hold, 0);

    // Store never completes: timeout after MEM_TIMEOUT frozen wait cycles
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("toFreeze%0d", i), pc_hold, 1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("toReleasePc", pc_hold, 0);
    checkOutput("toErrNotYet", err_timeout, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("toErrSet", err_timeout, 1);
    checkOutput("toStallCnt", stall_cnt, 5);
    nextCycle();
    @(negedge clk);
    checkOutput("toErrSticky", err_timeout, 1);
    resetDut();
    @(negedge clk);
    checkOutput("toErrCleared", err_timeout, 0);

    // clr in the middle of a wait returns straight to RUN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) nextCycle();
    clr = 1'b1;
    @(negedge clk);
    checkOutput("midClrPcHold", pc_hold, 0);
    checkOutput("midClrWbFlush", memwb_flush, 0);
    nextCycle();
    clr = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("midClrRun", pc_hold, 0);
    checkOutput("midClrStallCnt", stall_cnt, 0);

    // Both counters saturate at all-ones
    applyStimulus(8, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    repeat (9) nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (9) nextCycle();
    @(negedge clk);
    checkOutput("satStallCnt", stall_cnt, CNT_MAX);
    checkOutput("satFlushCnt", flush_cnt, CNT_MAX);

    nextCycle();
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the freeze and flush inputs of the PC register and of the if2id, id2exe, exe2mem and mem2wb stage registers.
- Detects load-use hazards in ID and redirects on branch/jump resolved in MEM.
- Runs a small FSM that freezes the pipeline while a MEM-stage data access waits on a slow memory, with a timeout error.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- MEM_TIMEOUT, 64, maximum cycles in MEM_WAIT before `err_timeout` sets (≥2).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_writeReg  in  5  destination register of the instruction in EX.
- ex_MemToReg  in  1  instruction in EX is a load.
- mem_BranchEq  in  1  exe2mem BranchEq bit.
- mem_zero  in  1  exe2mem zero bit.
- mem_Jump  in  1  exe2mem Jump bit.
- mem_MemToReg  in  1  load in MEM.
- mem_MemWrite  in  1  store in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC does not update.
- ifid_hold  out  1  if2id keeps its value.
- ifid_flush  out  1  if2id loads zero.
- idex_hold  out  1  id2exe keeps its value.
- idex_flush  out  1  id2exe loads zero.
- exmem_hold  out  1  exe2mem keeps its value.
- exmem_flush  out  1  exe2mem loads zero (drives its `flush`).
- memwb_flush  out  1  mem2wb loads zero.
- pc_src  out  2  0 = PC+4, 1 = pcBranch, 2 = jump target.
- err_timeout  out  1  sticky; set when a memory wait exceeds MEM_TIMEOUT.
- stall_cnt  out  CNT_W  cycles with pc_hold asserted, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Reset (clr=1): state=RUN, wait counter=0, err_timeout=0, stall_cnt=0, flush_cnt=0. All hold/flush outputs are 0 and pc_src=0 while clr=1.
- Combinational terms:
  - taken = mem_BranchEq & mem_zero.
  - redirect = taken | mem_Jump.
  - mem_req = mem_MemToReg | mem_MemWrite.
  - load_use = ex_MemToReg & ex_writeReg≠0 & (ex_writeReg==id_rs | (id_uses_rt & ex_writeReg==id_rt)).
- State RUN:
  - If mem_req & !mem_ready: go to MEM_WAIT and apply the freeze set this cycle: pc_hold, ifid_hold, idex_hold, exmem_hold = 1 and memwb_flush = 1 (bubble into WB).
  - Else if redirect: ifid_flush, idex_flush, exmem_flush = 1. pc_src = 2 if mem_Jump, else 1. flush_cnt += 1.
  - Else if load_use: pc_hold = 1, ifid_hold = 1, idex_flush = 1 (one bubble). Stall lasts exactly 1 cycle, since the load then moves to MEM.
  - Else: all control outputs 0.
- State MEM_WAIT:
  - Freeze set asserted every cycle; wait counter increments.
  - mem_ready=1: release the freeze this same cycle (all hold=0, memwb_flush=0), counter clears, go to RUN.
  - Counter reaches MEM_TIMEOUT without ready: set err_timeout, go to RUN, release the freeze.
- Priority:
  - Memory wait over redirect. They cannot coexist for legal instructions, but if both inputs are set, the wait wins.
  - Redirect over load_use: the flush kills the ID instruction, so no stall is issued.
- A hold and a flush on the same register are never asserted together.
- stall_cnt increments on every cycle with pc_hold=1 and saturates at all-ones. flush_cnt saturates the same way.
- clr mid-MEM_WAIT: immediate return to RUN with everything cleared.
- Latency: every output is a function of the current state and inputs, so there is zero-cycle response. State and counters update on the rising clk edge.

Decomposition:
- Shared package:
  - state encoding: RUN=1'b0, MEM_WAIT=1'b1;
  - pc_src codes PCSRC_SEQ=2'd0, PCSRC_BR=2'd1, PCSRC_J=2'd2;
  - register-0 constant.
- One natural sub-module, `sat_counter` (width parameter, inc, clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset release: clr pulse with load_use inputs active → all outputs 0 during clr; stall_cnt=0, flush_cnt=0.
- Load-use: EX lw $8, ID add $9,$8,$1 → one cycle with pc_hold=1, ifid_hold=1, idex_flush=1; next cycle all 0; stall_cnt=1. Repeat with ex_writeReg=0 → no stall.
- Taken branch: mem_BranchEq=1, mem_zero=1 → ifid/idex/exmem_flush=1, pc_src=1, flush_cnt=1. With mem_zero=0 → no flush, pc_src=0.
- Jump plus simultaneous load-use: mem_Jump=1 and load_use true → flushes asserted, pc_src=2, pc_hold=0, stall_cnt unchanged.
- Memory wait: mem_MemToReg=1, mem_ready low for 3 cycles, then high → freeze set for 3 cycles, released in the ready cycle, state back to RUN, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → err_timeout rises after 4 wait cycles and stays 1 until clr; assert clr mid-wait in a second run → immediate return to RUN.
